// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address stack controller.
// Arbitrates two requesters (0 = core call/return path, 1 = exception unit)
// onto an 8-entry stack that wraps silently. The controller tracks occupancy,
// rejects overflow/underflow before they reach the stack, and drains the stack
// with back-to-back pops on flush.
// Optional feature: define RAS_CTRL_RR_EN for round-robin arbitration when both
// requesters are valid; otherwise requester 1 always wins.
module ras_ctrl #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              flush,
  output logic              flush_busy,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [CNT_W-1:0]  depth,
  output logic              full,
  output logic              empty,
  output logic              ovf_sticky,
  output logic              unf_sticky,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DZERO_C = {DATA_W{1'b0}};

  state_t             state_r, state_d;
  logic [CNT_W-1:0]   depth_r, depth_d;
  logic               full_r, empty_r;
  logic               pend_r, pend_clr_s, blocked_s;
  logic [1:0]         grant_s;
  logic               xfer_s, xfer_id_s, xfer_op_s;
  logic [DATA_W-1:0]  xfer_data_s;
  logic               push_ok_s, pop_ok_s, ovf_set_s, unf_set_s, flush_pop_s;
  logic               rsp_valid_r, rsp_id_r, rsp_err_r;
  logic [DATA_W-1:0]  rsp_data_r, stk_din_r;
  logic               stk_push_r, stk_pop_r;
  logic               ovf_r, unf_r;
`ifdef RAS_CTRL_RR_EN
  logic               last_r;
`endif

  // Grant, op qualification and next-state / next-depth decode.
  always_comb begin
    state_d     = state_r;
    depth_d     = depth_r;
    pend_clr_s  = 1'b0;
    grant_s     = 2'b00;
    blocked_s   = pend_r | flush;
    if ((state_r == ST_IDLE) && !blocked_s) begin
      if (req_valid == 2'b11) begin
`ifdef RAS_CTRL_RR_EN
        grant_s = last_r ? 2'b01 : 2'b10;
`else
        grant_s = 2'b10;
`endif
      end else begin
        grant_s = req_valid;
      end
    end else begin
      grant_s = 2'b00;
    end

    xfer_s      = |grant_s;
    xfer_id_s   = grant_s[1];
    xfer_op_s   = req_op[xfer_id_s];
    xfer_data_s = xfer_id_s ? req_data1 : req_data0;
    push_ok_s   = xfer_s &  xfer_op_s & (depth_r != DEPTH_C);
    ovf_set_s   = xfer_s &  xfer_op_s & (depth_r == DEPTH_C);
    pop_ok_s    = xfer_s & ~xfer_op_s & (depth_r != ZERO_C);
    unf_set_s   = xfer_s & ~xfer_op_s & (depth_r == ZERO_C);

    case (state_r)
      ST_IDLE: begin
        if (blocked_s) begin
          state_d = ST_FLUSH;
        end else if (xfer_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_FLUSH: begin
        if (depth_r == ZERO_C) begin
          state_d    = ST_IDLE;
          pend_clr_s = 1'b1;
        end else begin
          state_d    = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push_ok_s) begin
      depth_d = depth_r + ONE_C;
    end else if (pop_ok_s) begin
      depth_d = depth_r - ONE_C;
    end else if ((state_r == ST_FLUSH) && (depth_r != ZERO_C)) begin
      depth_d = depth_r - ONE_C;
    end else begin
      depth_d = depth_r;
    end

    // A flush pop is issued registered, one per FLUSH cycle that still has
    // entries, so depth shows the pre-pop count during each pop cycle.
    flush_pop_s = (state_d == ST_FLUSH) && (depth_d != ZERO_C);
  end

  // State, occupancy, response and stack-control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      depth_r     <= ZERO_C;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      pend_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_data_r  <= DZERO_C;
      rsp_err_r   <= 1'b0;
      stk_push_r  <= 1'b0;
      stk_pop_r   <= 1'b0;
      stk_din_r   <= DZERO_C;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      state_r     <= state_d;
      depth_r     <= depth_d;
      full_r      <= (depth_d == DEPTH_C);
      empty_r     <= (depth_d == ZERO_C);
      pend_r      <= flush | (pend_r & ~pend_clr_s);
      rsp_valid_r <= xfer_s;
      rsp_id_r    <= xfer_s ? xfer_id_s : 1'b0;
      rsp_data_r  <= pop_ok_s ? stk_dout : DZERO_C;
      rsp_err_r   <= ovf_set_s | unf_set_s;
      stk_push_r  <= push_ok_s;
      stk_pop_r   <= pop_ok_s | flush_pop_s;
      stk_din_r   <= push_ok_s ? xfer_data_s : stk_din_r;
      ovf_r       <= ovf_set_s | (ovf_r & ~err_clr);
      unf_r       <= unf_set_s | (unf_r & ~err_clr);
    end
  end

`ifdef RAS_CTRL_RR_EN
  // Remember the last granted requester for round-robin fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (xfer_s) begin
      last_r <= xfer_id_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign req_ready  = grant_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;
  assign flush_busy = pend_r | (state_r == ST_FLUSH);
  assign stk_push   = stk_push_r;
  assign stk_pop    = stk_pop_r;
  assign stk_din    = stk_din_r;
  assign depth      = depth_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign ovf_sticky = ovf_r;
  assign unf_sticky = unf_r;

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed scenarios plus randomized traffic for ras_ctrl,
// compared every cycle against a transaction-level model (queue-based stack).
// Honours RAS_CTRL_RR_EN in the model and in the contention expectations.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_op, req_ready;
  logic [11:0] req_data0, req_data1;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [11:0] rsp_data;
  logic        flush, flush_busy, stk_push, stk_pop;
  logic [11:0] stk_din, stk_dout;
  logic [3:0]  depth;
  logic        full, empty, ovf_sticky, unf_sticky, err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  ras_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flush(flush), .flush_busy(flush_busy), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_din(stk_din), .stk_dout(stk_dout), .depth(depth), .full(full), .empty(empty),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Environment: the wrapping hardware stack itself.
  logic [11:0] smem [8];
  logic [2:0]  ssp;
  always @(posedge clk) begin
    if (rst) ssp <= 3'd0;
    else if (stk_push) begin smem[ssp] <= stk_din; ssp <= ssp + 3'd1; end
    else if (stk_pop) ssp <= ssp - 3'd1;
  end
  assign stk_dout = smem[ssp - 3'd1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_q[$];
  bit          m_on = 0, m_exec, m_pend, m_last, m_ovf, m_unf;
  int          m_fl;                 // remaining flush cycles, 0 = not flushing
  bit          e_rv, e_id, e_err, e_push, e_pop;
  logic [11:0] e_data, e_din;

  function automatic logic [1:0] mgrant();
    if (m_exec || m_fl > 0 || m_pend || flush) return 2'b00;
    if (req_valid == 2'b11) begin
`ifdef RAS_CTRL_RR_EN
      return m_last ? 2'b01 : 2'b10;
`else
      return 2'b10;
`endif
    end
    return req_valid;
  endfunction

  task automatic compare();
    bit fpop;
    fpop = (m_fl > 0) && (m_q.size() > 0);
    chk("req_ready", req_ready, mgrant());
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv) begin
      chk("rsp_id", rsp_id, e_id);
      chk("rsp_data", rsp_data, e_data);
      chk("rsp_err", rsp_err, e_err);
    end
    chk("stk_push", stk_push, e_push);
    chk("stk_pop", stk_pop, e_pop | fpop);
    if (e_push) chk("stk_din", stk_din, e_din);
    chk("depth", depth, m_q.size());
    chk("full", full, m_q.size() == 8);
    chk("empty", empty, m_q.size() == 0);
    chk("ovf_sticky", ovf_sticky, m_ovf);
    chk("unf_sticky", unf_sticky, m_unf);
    chk("flush_busy", flush_busy, m_pend || (m_fl > 0));
  endtask

  task automatic step();
    logic [1:0]  g;
    logic [11:0] d;
    int id;
    bit clr, so, su;
    if (rst) begin
      m_on = 1; m_q.delete(); m_exec = 0; m_pend = 0; m_last = 1; m_fl = 0;
      m_ovf = 0; m_unf = 0; e_rv = 0; e_id = 0; e_err = 0; e_push = 0; e_pop = 0;
      e_data = 12'd0;
      return;
    end
    if (!m_on) return;
    g = mgrant();
    clr = 0; so = 0; su = 0;
    e_rv = 0; e_push = 0; e_pop = 0; e_err = 0; e_data = 12'd0;
    if (m_fl > 0) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      m_fl--;
      if (m_fl == 0) clr = 1;
    end else if (!m_exec && (m_pend || flush)) begin
      m_fl = m_q.size() + 1;     // one pop per entry, then one empty cycle
    end
    if (g != 2'b00) begin
      id = g[1] ? 1 : 0;
      d  = (id == 1) ? req_data1 : req_data0;
      e_rv = 1; e_id = g[1];
      if (req_op[id]) begin
        if (m_q.size() >= 8) begin e_err = 1; so = 1; end
        else begin m_q.push_back(d); e_push = 1; e_din = d; end
      end else begin
        if (m_q.size() == 0) begin e_err = 1; su = 1; end
        else begin e_data = m_q[$]; void'(m_q.pop_back()); e_pop = 1; end
      end
      m_last = g[1];
    end
    m_exec = (g != 2'b00);
    m_pend = flush || (m_pend && !clr);
    m_ovf  = so || (m_ovf && !err_clr);
    m_unf  = su || (m_unf && !err_clr);
  endtask

  // Compare process: DUT vs model every cycle, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_on) compare();
      step();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_op(input int id, input bit op, input logic [11:0] d);
    int n = 0;
    bit done = 0;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    if (id == 0) req_data0 = d; else req_data1 = d;
    while (!done && n < 50) begin
      #1 done = req_ready[id];
      @(negedge clk);
      n++;
    end
    req_valid[id] = 1'b0;
    chk("op_handshake", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  logic [1:0]  g, gprev;
  int          order[2];
  int          cnt, pops, first_pop, last_pop, ready_k, bad, bias;
  logic [11:0] rd;
  logic [3:0]  dep_at_ready;
  logic        busy_at_ready;

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_op = 2'b00; req_data0 = 12'd0; req_data1 = 12'd0;
    flush = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_depth", depth, 0);
    chk("reset_empty", empty, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_stk_push", stk_push, 0);
    chk("reset_stk_pop", stk_pop, 0);
    chk("reset_flush_busy", flush_busy, 0);

    // Contention: both push, held until granted.
    req_valid = 2'b11; req_op = 2'b11; req_data0 = 12'd100; req_data1 = 12'd200;
    cnt = 0;
    for (int n = 0; n < 20 && req_valid != 2'b00; n++) begin
      #1 g = req_ready;
      @(negedge clk);
      if (g != 2'b00) begin
        if (cnt < 2) order[cnt] = g[1] ? 1 : 0;
        cnt++;
        req_valid = req_valid & ~g;
        #1;
        chk("cont_rsp_valid", rsp_valid, 1);
        chk("cont_rsp_id", rsp_id, g[1]);
      end
    end
    chk("cont_grants", cnt, 2);
`ifdef RAS_CTRL_RR_EN
    chk("cont_first", order[0], 0);
    chk("cont_second", order[1], 1);
    rd = 12'd200;
`else
    chk("cont_first", order[0], 1);
    chk("cont_second", order[1], 0);
    rd = 12'd100;
`endif
    do_op(0, 1'b0, 12'd0);
    #1 chk("cont_top", rsp_data, rd);
    do_reset();

    // Single push / pop.
    do_op(0, 1'b1, 12'd31);
    #1;
    chk("push_stk_push", stk_push, 1);
    chk("push_depth", depth, 1);
    do_op(0, 1'b0, 12'd0);
    #1;
    chk("pop_data", rsp_data, 31);
    chk("pop_err", rsp_err, 0);
    chk("pop_depth", depth, 0);
    chk("pop_empty", empty, 1);

    // Overflow / underflow.
    for (int i = 1; i <= 8; i++) do_op(0, 1'b1, 12'(i));
    #1 chk("ovf_full", full, 1);
    do_op(0, 1'b1, 12'd9);
    #1;
    chk("ovf_err", rsp_err, 1);
    chk("ovf_sticky", ovf_sticky, 1);
    chk("ovf_no_push", stk_push, 0);
    chk("ovf_depth", depth, 8);
    do_op(1, 1'b0, 12'd0);
    #1 chk("ovf_pop_data", rsp_data, 8);
    for (int i = 0; i < 7; i++) do_op(0, 1'b0, 12'd0);
    do_op(0, 1'b0, 12'd0);
    #1;
    chk("unf_err", rsp_err, 1);
    chk("unf_sticky", unf_sticky, 1);
    chk("unf_data", rsp_data, 0);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    chk("clr_ovf", ovf_sticky, 0);
    chk("clr_unf", unf_sticky, 0);

    // Flush from IDLE with depth 5, requester 0 waiting to push.
    for (int i = 0; i < 5; i++) do_op(0, 1'b1, 12'(11 + i));
    @(negedge clk);
    flush = 1'b1; req_valid[0] = 1'b1; req_op[0] = 1'b1; req_data0 = 12'd7;
    pops = 0; first_pop = 0; last_pop = 0; ready_k = 0;
    for (int k = 1; k <= 20 && ready_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) flush = 1'b0;
      #1;
      if (stk_pop) begin pops++; if (first_pop == 0) first_pop = k; last_pop = k; end
      if (req_ready[0]) begin ready_k = k; dep_at_ready = depth; busy_at_ready = flush_busy; end
    end
    @(negedge clk); req_valid[0] = 1'b0;
    chk("flush_pops", pops, 5);
    chk("flush_first_pop", first_pop, 1);
    chk("flush_last_pop", last_pop, 5);
    chk("flush_ready_k", ready_k, 7);
    chk("flush_depth", dep_at_ready, 0);
    chk("flush_busy_end", busy_at_ready, 0);

    // Flush pulsed during the EXEC cycle of a push (depth 1 -> 2).
    do_op(0, 1'b1, 12'd50);
    #1 chk("fexec_push", stk_push, 1);
    flush = 1'b1; req_valid[1] = 1'b1; req_op[1] = 1'b0;
    pops = 0; first_pop = 0; ready_k = 0; bad = 0;
    for (int k = 1; k <= 20 && ready_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) flush = 1'b0;
      #1;
      if (stk_pop) begin pops++; if (first_pop == 0) first_pop = k; end
      if (req_ready != 2'b00 && flush_busy) bad++;
      if (req_ready[1]) ready_k = k;
    end
    @(negedge clk); req_valid[1] = 1'b0;
    chk("fexec_pops", pops, 2);
    chk("fexec_first_pop", first_pop, 2);
    chk("fexec_ready_k", ready_k, 5);
    chk("fexec_no_grant", bad, 0);

    // Reset in the middle of a flush.
    for (int i = 0; i < 3; i++) do_op(0, 1'b1, 12'(60 + i));
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; req_valid[0] = 1'b1; req_op[0] = 1'b0;
    #1;
    chk("rstf_depth", depth, 0);
    chk("rstf_busy", flush_busy, 0);
    chk("rstf_pop", stk_pop, 0);
    chk("rstf_push", stk_push, 0);
    chk("rstf_rsp_valid", rsp_valid, 0);
    chk("rstf_unf", unf_sticky, 0);
    chk("rstf_empty", empty, 1);
    chk("rstf_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00;

    // Randomized traffic; requesters hold op/data until granted.
    gprev = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bias = (c < 700) ? 7 : 5;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || gprev[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_op[i]    = ($urandom_range(0, 9) < bias);
          if (i == 0) req_data0 = 12'($urandom); else req_data1 = 12'($urandom);
        end
      end
      flush   = ($urandom_range(0, 49) == 0);
      err_clr = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      #1 gprev = rst ? 2'b00 : (req_ready & req_valid);
    end
    @(negedge clk);
    req_valid = 2'b00; flush = 1'b0; err_clr = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address stack controller. It sequences the 8-entry, 12-bit hardware stack that holds `jal` return addresses, and shares that stack between two requesters: the core's call/return path (requester 0) and the exception unit (requester 1). The block arbitrates requests, tracks stack depth, and rejects overflow and underflow before they reach the stack, since the stack itself wraps silently. It also supports a flush that drains the stack by issuing back-to-back pops.

## Interface
- `DATA_W`, 12: stack word width.
- `DEPTH`, 8: stack entries; must match the stack instance.
- `CNT_W`, 4: depth counter width; must be ≥ clog2(`DEPTH`+1).
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: bit i = requester i has an op pending.
- `req_op` in 2: bit i = op of requester i; 1 = push, 0 = pop.
- `req_data0`, `req_data1` in `DATA_W`: push data of requester 0 and requester 1.
- `req_ready` out 2: one-hot grant. An op transfers when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: one-cycle pulse per accepted op.
- `rsp_id` out 1: requester that owns the response.
- `rsp_data` out `DATA_W`: popped word; 0 for a push or a rejected op.
- `rsp_err` out 1: op rejected (overflow or underflow).
- `flush` in 1: single-cycle request to empty the stack.
- `flush_busy` out 1: flush pending or in progress.
- `stk_push`, `stk_pop` out 1: stack controls. Registered, never both high.
- `stk_din` out `DATA_W`: registered push data.
- `stk_dout` in `DATA_W`: stack top word (combinational from the stack).
- `depth` out `CNT_W`: current occupancy.
- `full`, `empty` out 1: `depth==DEPTH`, `depth==0`.
- `ovf_sticky`, `unf_sticky` out 1: sticky error flags.
- `err_clr` in 1: clears both sticky flags.

## Operation
**FSM states**
- IDLE: no stack op issued; may accept a request.
  - `flush` pending → FLUSH (flush has priority over requests).
  - Otherwise, any granted transfer → EXEC.
- EXEC: one cycle; `req_ready`=0; → IDLE.
- FLUSH: `req_ready`=0.
  - `depth>0`: assert `stk_pop`, `depth`−1 per cycle.
  - `depth==0`: → IDLE and clear the pending flag.
  - A flush with `depth==0` spends one cycle in FLUSH with no pop.

**Flush pending**
- A `flush` pulse in any state sets a pending register.
- `flush_busy` = pending | (state==FLUSH).

**Grant (IDLE only, no flush pending)**
- With exactly one requester valid, that requester is granted.
- With both valid, the arbitration rule is set by the macro in Configuration.

**Accepted push**
- Not full: `stk_din`←data, `stk_push`←1, `depth`+1, `rsp_data`←0.
- Full: no stack op, `rsp_err`←1, `ovf_sticky`←1.

**Accepted pop**
- Not empty: `rsp_data`←`stk_dout` (top before the pop), `stk_pop`←1, `depth`−1.
- Empty: no stack op, `rsp_err`←1, `unf_sticky`←1, `rsp_data`←0.

**Sticky flags**
- A set and an `err_clr` in the same cycle: set wins.

**Reset values**
- state=IDLE, `depth`=0, all pulses/flags/`rsp_*`/`stk_*`=0.
- Flush pending=0, last-grant=1.
- `rst` is applied only together with the stack's own initialisation. To recover mid-operation without reset, issue `flush`.

## Timing
**Accepted op (transfer in cycle N)**
- Cycle N+1: `stk_push`/`stk_pop`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err` high/valid.
- Cycle N+1: updated `depth`, `full`, `empty` visible.
- The stack commits at the end of N+1.
- `req_ready` can next be high in N+2. Peak throughput is one op per 2 cycles.

**Grant and handshake**
- `req_ready` is combinational from state, pending flush, `req_valid`, and last-grant.
- A requester holds `req_op`/data stable while valid and not ready.

**Flush**
- Pulse in IDLE cycle N: FLUSH from N+1.
- Pops on N+1 … N+`depth`.
- IDLE in cycle N+`depth`+2.

## Configuration
- Macro `RAS_CTRL_RR_EN`, defined: round-robin arbitration.
  - Both valid → grant the requester not granted last.
  - Last-grant updates on every transfer; reset value 1, so requester 0 wins first.
- Undefined: fixed priority; requester 1 (exception unit) always wins. The last-grant register is not built.

## Test plan
- **Single push/pop:** reset; req0 push 12'd31 → `stk_push` 1 cycle later, `depth`=1. Then req0 pop → `rsp_data`=31, `rsp_err`=0, `depth`=0, `empty`=1.
- **Overflow/underflow:** 8 pushes (12'd1..12'd8) → `full`=1. 9th push → `rsp_err`=1, `ovf_sticky`=1, no `stk_push`. Then pop → 12'd8. From empty, pop → `rsp_err`=1, `unf_sticky`=1. `err_clr` → both flags 0.
- **Contention:** both valid, push 12'd100 (req0) and 12'd200 (req1), held. RR build: grants req0 then req1. Fixed build: req1 first. Response `rsp_id` matches the grant.
- **Flush:** `depth`=5, then `flush` pulse → exactly 5 consecutive `stk_pop` cycles, `depth` reaches 0, `flush_busy` drops, `req_ready` resumes 2 cycles after the last pop.
- **Flush during EXEC:** pulse `flush` in the EXEC cycle of a push. The push completes; FLUSH starts from the next IDLE cycle; no request is granted meanwhile.
- **Reset mid-flush:** assert `rst` during FLUSH → next cycle IDLE, `depth`=0, all outputs 0, `flush_busy`=0.
